// File: rtl/nic_input_port_rr_pkg.sv
// Shared definitions for the NIC input port: flit field layout, flit type
// encodings, per-VC reassembly states and a constant clog2 helper.
package nic_input_port_rr_pkg;

  // Flit field positions
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 2;
  localparam int VC_LSB   = 2;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_HT   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE = 2'b00,
    VC_RECV = 2'b01,
    VC_DONE = 2'b10
  } vc_state_e;

  // Width needed to hold values 0..n-1; never narrower than one bit so a
  // single-VC build still gets a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nic_input_port_rr_vc_reassembly_buffer.sv
// One virtual-channel reassembly buffer: collects head/body/tail flits into
// a slot array, holds the finished packet until the arbiter accepts it, and
// reports credit, idle and sticky protocol-error status.
module nic_vc_reassembly_buffer
  import nic_input_port_rr_pkg::*;
#(
  parameter int FLIT_WIDTH        = 16,
  parameter int MAX_PACKET_LENGTH = 5,
  parameter int N_BITS_LEN        = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FLIT_WIDTH-1:0]                 flit_i,
  input  logic                                  wr_i,
  input  logic                                  accept_i,
  output logic                                  done_o,
  output logic                                  free_o,
  output logic                                  credit_o,
  output logic                                  err_o,
  output logic [N_BITS_LEN-1:0]                 len_o,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] link_o
);

  localparam logic [N_BITS_LEN-1:0] LEN_FULL = N_BITS_LEN'(MAX_PACKET_LENGTH);

  vc_state_e                                        state_q, state_d;
  logic [N_BITS_LEN-1:0]                            cnt_q, cnt_d;
  logic [MAX_PACKET_LENGTH-1:0][FLIT_WIDTH-1:0]     slots_q, slots_d;
  logic                                             err_q, err_d;
  logic                                             credit_q, credit_d;
  flit_type_e                                       ftype;

  assign ftype = flit_type_e'(flit_i[TYPE_LSB +: TYPE_W]);

  // State, counter, slot array and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= VC_IDLE;
      cnt_q    <= '0;
      slots_q  <= '0;
      err_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slots_q  <= slots_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  // Next-state: flit acceptance, protocol checks and release on accept.
  // Illegal flits are dropped; only overflow also tears the VC down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slots_d  = slots_q;
    err_d    = err_q;
    credit_d = 1'b0;
    case (state_q)
      VC_IDLE: begin
        if (wr_i) begin
          if (ftype == FLIT_HEAD || ftype == FLIT_HT) begin
            slots_d[0] = flit_i;
            cnt_d      = N_BITS_LEN'(1);
            state_d    = (ftype == FLIT_HT) ? VC_DONE : VC_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      VC_RECV: begin
        if (wr_i) begin
          if (ftype == FLIT_HEAD || ftype == FLIT_HT) begin
            err_d = 1'b1;
          end else if (cnt_q == LEN_FULL) begin
            // Packet longer than the buffer: give the VC back clean
            err_d    = 1'b1;
            state_d  = VC_IDLE;
            cnt_d    = '0;
            slots_d  = '0;
            credit_d = 1'b1;
          end else begin
            for (int k = 0; k < MAX_PACKET_LENGTH; k++) begin
              if (cnt_q == N_BITS_LEN'(k)) slots_d[k] = flit_i;
            end
            cnt_d = cnt_q + N_BITS_LEN'(1);
            if (ftype == FLIT_TAIL) state_d = VC_DONE;
          end
        end
      end
      VC_DONE: begin
        if (wr_i) err_d = 1'b1;
        if (accept_i) begin
          state_d  = VC_IDLE;
          cnt_d    = '0;
          slots_d  = '0;
          credit_d = 1'b1;
        end
      end
      default: begin
        state_d = VC_IDLE;
        cnt_d   = '0;
        slots_d = '0;
      end
    endcase
  end

  // Outputs derived from registered state only
  always_comb begin
    done_o   = (state_q == VC_DONE);
    free_o   = (state_q == VC_IDLE);
    credit_o = credit_q;
    err_o    = err_q;
    len_o    = cnt_q;
    link_o   = slots_q;
  end

endmodule

// File: rtl/nic_input_port_rr.sv
// NIC input port: demultiplexes router flits into per-VC reassembly buffers
// and presents completed packets to pkt_to_msg through a round-robin
// arbiter with a valid/stall handshake.
module nic_input_port_rr
  import nic_input_port_rr_pkg::*;
#(
  parameter  int FLIT_WIDTH        = 16,
  parameter  int N_OF_VN           = 2,
  parameter  int N_OF_VC           = 2,
  parameter  int MAX_PACKET_LENGTH = 5,
  localparam int N_TOT_OF_VC       = N_OF_VN * N_OF_VC,
  localparam int N_BITS_POINTER    = clog2(N_TOT_OF_VC),
  localparam int N_BITS_LEN        = clog2(MAX_PACKET_LENGTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [FLIT_WIDTH-1:0]                   in_link_i,
  input  logic                                    is_valid_i,
  output logic [N_TOT_OF_VC-1:0]                  credit_signal_o,
  output logic [N_TOT_OF_VC-1:0]                  free_signal_o,
  output logic [N_TOT_OF_VC-1:0]                  err_o,
  input  logic                                    stall_pkt_to_msg_i,
  output logic                                    r_pkt_to_msg_o,
  output logic [N_BITS_POINTER-1:0]               out_vc_o,
  output logic [N_BITS_LEN-1:0]                   out_len_o,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] out_link_o
);

  localparam int PKT_W = MAX_PACKET_LENGTH * FLIT_WIDTH;

  logic [N_BITS_POINTER-1:0]                  vc_id;
  logic [N_TOT_OF_VC-1:0]                     wr_vec;
  logic [N_TOT_OF_VC-1:0]                     accept_vec;
  logic [N_TOT_OF_VC-1:0]                     done_vec;
  logic [N_TOT_OF_VC-1:0][N_BITS_LEN-1:0]     len_all;
  logic [N_TOT_OF_VC-1:0][PKT_W-1:0]          link_all;

  logic [N_BITS_POINTER-1:0]                  rr_q, rr_d;
  logic                                       lock_vld_q, lock_vld_d;
  logic [N_BITS_POINTER-1:0]                  lock_vc_q, lock_vc_d;

  logic [2*N_TOT_OF_VC-1:0]                   dbl;
  logic [N_TOT_OF_VC-1:0]                     rot;
  logic                                       found;
  logic [N_BITS_POINTER-1:0]                  search_vc;
  int                                         idx;

  logic [N_BITS_POINTER-1:0]                  gnt_vc;
  logic                                       pkt_vld;
  logic                                       accept;

  assign vc_id = in_link_i[VC_LSB +: N_BITS_POINTER];

  for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
    assign wr_vec[v]     = is_valid_i && (vc_id == N_BITS_POINTER'(v));
    assign accept_vec[v] = accept && (gnt_vc == N_BITS_POINTER'(v));

    nic_vc_reassembly_buffer #(
      .FLIT_WIDTH        (FLIT_WIDTH),
      .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
      .N_BITS_LEN        (N_BITS_LEN)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flit_i   (in_link_i),
      .wr_i     (wr_vec[v]),
      .accept_i (accept_vec[v]),
      .done_o   (done_vec[v]),
      .free_o   (free_signal_o[v]),
      .credit_o (credit_signal_o[v]),
      .err_o    (err_o[v]),
      .len_o    (len_all[v]),
      .link_o   (link_all[v])
    );
  end

  // First DONE VC at or after rr: rotate the done vector so rr lands at
  // bit 0, take the lowest set bit, then map back with a wrap.
  always_comb begin
    dbl       = {done_vec, done_vec} >> rr_q;
    rot       = dbl[N_TOT_OF_VC-1:0];
    found     = 1'b0;
    search_vc = '0;
    idx       = 0;
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = int'(rr_q) + i;
        if (idx >= N_TOT_OF_VC) idx = idx - N_TOT_OF_VC;
        search_vc = N_BITS_POINTER'(idx);
      end
    end
  end

  // A stalled presentation is pinned so a newly completed VC ahead of it in
  // rr order cannot steal the grant mid-handshake.
  always_comb begin
    gnt_vc     = lock_vld_q ? lock_vc_q : search_vc;
    pkt_vld    = lock_vld_q | found;
    accept     = pkt_vld & ~stall_pkt_to_msg_i;
    lock_vld_d = pkt_vld & stall_pkt_to_msg_i;
    lock_vc_d  = gnt_vc;
    rr_d       = rr_q;
    if (accept) begin
      rr_d = (gnt_vc == N_BITS_POINTER'(N_TOT_OF_VC - 1)) ? '0
                                                           : gnt_vc + N_BITS_POINTER'(1);
    end
  end

  // Round-robin pointer and grant lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= '0;
      lock_vld_q <= 1'b0;
      lock_vc_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_vc_q  <= lock_vc_d;
    end
  end

  // Output mux; all packet fields read zero when nothing is presented
  always_comb begin
    r_pkt_to_msg_o = pkt_vld;
    out_vc_o       = '0;
    out_len_o      = '0;
    out_link_o     = '0;
    if (pkt_vld) begin
      out_vc_o   = gnt_vc;
      out_len_o  = len_all[gnt_vc];
      out_link_o = link_all[gnt_vc];
    end
  end

endmodule

// File: tb/tb_nic_input_port_rr.sv
// Bench for nic_input_port_rr: directed scenarios followed by random traffic,
// every cycle compared against a queue-based packet model.
module tb_nic_input_port_rr;

  localparam int FW   = 16;
  localparam int NV   = 4;
  localparam int MAXL = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [FW-1:0]   in_link;
  logic            is_valid;
  logic [NV-1:0]   credit, free_s, err;
  logic            stall;
  logic            r;
  logic [1:0]      out_vc;
  logic [2:0]      out_len;
  logic [MAXL*FW-1:0] out_link;

  int total = 0;
  int bad   = 0;

  // Reference model: one flit queue per VC plus open/complete flags
  logic [FW-1:0] mq [NV][$];
  bit            m_open [NV];
  bit            m_done [NV];
  bit            m_err  [NV];
  logic [NV-1:0] m_credit;
  int            m_rr;
  int            m_pres;

  nic_input_port_rr dut (
    .clk                (clk),
    .rst                (rst),
    .in_link_i          (in_link),
    .is_valid_i         (is_valid),
    .credit_signal_o    (credit),
    .free_signal_o      (free_s),
    .err_o              (err),
    .stall_pkt_to_msg_i (stall),
    .r_pkt_to_msg_o     (r),
    .out_vc_o           (out_vc),
    .out_len_o          (out_len),
    .out_link_o         (out_link)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int search();
    for (int i = 0; i < NV; i++) begin
      if (m_done[(m_rr + i) % NV]) return (m_rr + i) % NV;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      m_open[v] = 0;
      m_done[v] = 0;
      m_err[v]  = 0;
    end
    m_rr     = 0;
    m_pres   = -1;
    m_credit = '0;
  endtask

  // Apply one clock edge's worth of spec rules to the model
  task automatic model_edge(input logic [FW-1:0] f, input bit v, input bit s);
    int p;
    int vc;
    logic [1:0] t;
    p = m_pres;
    m_credit = '0;
    if (v) begin
      vc = int'(f[3:2]);
      t  = f[1:0];
      if (m_done[vc]) begin
        m_err[vc] = 1;
      end else if (!m_open[vc]) begin
        if (t == 2'b00) begin
          mq[vc].push_back(f); m_open[vc] = 1;
        end else if (t == 2'b11) begin
          mq[vc].push_back(f); m_done[vc] = 1;
        end else begin
          m_err[vc] = 1;
        end
      end else begin
        if (t == 2'b00 || t == 2'b11) begin
          m_err[vc] = 1;
        end else if (mq[vc].size() == MAXL) begin
          m_err[vc] = 1; mq[vc].delete(); m_open[vc] = 0; m_credit[vc] = 1'b1;
        end else begin
          mq[vc].push_back(f);
          if (t == 2'b10) begin m_open[vc] = 0; m_done[vc] = 1; end
        end
      end
    end
    if (p >= 0 && !s) begin
      mq[p].delete(); m_done[p] = 0; m_credit[p] = 1'b1; m_rr = (p + 1) % NV;
    end
    if (p >= 0 && s) m_pres = p;
    else             m_pres = search();
  endtask

  task automatic compare_all();
    logic [MAXL*FW-1:0] el;
    logic [NV-1:0] ef, ee;
    int p;
    p  = m_pres;
    el = '0;
    if (p >= 0) for (int k = 0; k < mq[p].size(); k++) el[k*FW +: FW] = mq[p][k];
    for (int v = 0; v < NV; v++) begin
      ef[v] = !m_open[v] && !m_done[v];
      ee[v] = m_err[v];
    end
    chk("r", r, (p >= 0) ? 1 : 0);
    chk("out_vc", out_vc, (p >= 0) ? p : 0);
    chk("out_len", out_len, (p >= 0) ? mq[p].size() : 0);
    chk("out_link", out_link, el);
    chk("credit", credit, m_credit);
    chk("free", free_s, ef);
    chk("err", err, ee);
  endtask

  task automatic step(input logic [FW-1:0] f, input bit v, input bit s);
    in_link  = f;
    is_valid = v;
    stall    = s;
    @(posedge clk);
    model_edge(f, v, s);
    #1;
    compare_all();
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [1:0]    t;
    int            vc;
    bit            vld;

    rst = 1'b0; in_link = '0; is_valid = 1'b0; stall = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_free", free_s, 4'hF);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;

    // Single packet on VC1, held by stall
    step(16'h0004, 1, 1); step(16'hBBB5, 1, 1); step(16'hCCC5, 1, 1);
    step(16'hDDD5, 1, 1); step(16'hFFF6, 1, 1);
    chk("sp_r", r, 1);
    chk("sp_vc", out_vc, 1);
    chk("sp_len", out_len, 5);
    chk("sp_link", out_link, 80'hFFF6_DDD5_CCC5_BBB5_0004);
    chk("sp_free1", free_s[1], 0);
    step(16'h0000, 0, 0);
    chk("sp_credit", credit, 4'b0010);
    chk("sp_free1_back", free_s[1], 1);
    chk("sp_r_low", r, 0);
    step(16'h0000, 0, 1);
    chk("sp_credit_once", credit, 4'b0000);

    // Arbitration among three completed VCs, released one cycle at a time
    step(16'h0004, 1, 1); step(16'h1115, 1, 1); step(16'h2225, 1, 1);
    step(16'h3335, 1, 1); step(16'h4446, 1, 1);
    step(16'h0003, 1, 1); step(16'hAAAF, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(16'h0000, 0, 0);
      step(16'h0000, 0, 1);
    end
    chk("arb_idle", r, 0);

    // Protocol errors on VC2: body while idle, then an overlong packet
    step(16'h0009, 1, 1);
    chk("pe_err2", err[2], 1);
    chk("pe_free2", free_s[2], 1);
    step(16'h0008, 1, 1);
    for (int i = 0; i < 4; i++) step(16'h0009, 1, 1);
    step(16'h0009, 1, 1);
    chk("pe_credit2", credit[2], 1);
    chk("pe_no_r", r, 0);
    chk("pe_err_sticky", err[2], 1);

    // Stall stability: VC3 completes while VC1 is held
    step(16'h0004, 1, 1); step(16'h1116, 1, 1);
    step(16'hAAAF, 1, 1);
    chk("stab_vc", out_vc, 1);
    chk("stab_link", out_link, 80'h0000_0000_0000_1116_0004);
    step(16'h0000, 0, 1);
    chk("stab_hold", out_vc, 1);
    step(16'h0000, 0, 0);
    chk("stab_next", out_vc, 3);

    // Reuse: head on VC1 while its credit pulses
    chk("reuse_credit", credit[1], 1);
    step(16'h0004, 1, 1);
    chk("reuse_free", free_s[1], 0);
    chk("reuse_err", err[1], 0);

    // Reset mid-packet
    step(16'hBBB5, 1, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("mr_free", free_s, 4'hF);
    @(posedge clk); #1;
    compare_all();
    #2 rst = 1'b1;
    step(16'h0007, 1, 1);
    chk("mr_r", r, 1);
    chk("mr_len", out_len, 1);
    chk("mr_vc", out_vc, 1);
    step(16'h0000, 0, 0);

    // Random traffic, mostly legal with injected protocol errors
    for (int c = 0; c < 3000; c++) begin
      vc  = $urandom_range(0, NV - 1);
      vld = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        t = 2'($urandom);
      end else if (m_done[vc]) begin
        t = 2'b01; vld = 0;
      end else if (!m_open[vc]) begin
        t = $urandom_range(0, 1) ? 2'b00 : 2'b11;
      end else begin
        t = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b01;
      end
      f = {12'($urandom), 2'(vc), t};
      step(f, vld, ($urandom_range(0, 4) < 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
